// File: rtl/p3_to_3_pkg.sv
// ============================================================================
//  Module      : p3_to_3_pkg
//  Description : Shared types and route-select constants for the p3_to_3 block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package p3_to_3_pkg;

    // Bit i of a vector carries position i (fin_i, fout_i, bin_i, bout_i).
    typedef logic [2:0] p3_vec_t;

    localparam logic PASS   = 1'b0;
    localparam logic ROTATE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/p3_to_3_if.sv
// ============================================================================
//  Module      : p3_to_3_if
//  Description : Forward/backward strobe, data and result bundle for p3_to_3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface p3_to_3_if;

    logic fvalid;
    logic fcontrol;
    logic fin0;
    logic fin1;
    logic fin2;

    logic bvalid;
    logic bin0;
    logic bin1;
    logic bin2;

    logic fout0;
    logic fout1;
    logic fout2;
    logic fvalid_out;

    logic bout0;
    logic bout1;
    logic bout2;
    logic bcontrol;
    logic bvalid_out;

    modport master (
        output fvalid, fcontrol, fin0, fin1, fin2,
        output bvalid, bin0, bin1, bin2,
        input  fout0, fout1, fout2, fvalid_out,
        input  bout0, bout1, bout2, bcontrol, bvalid_out
    );

    modport slave (
        input  fvalid, fcontrol, fin0, fin1, fin2,
        input  bvalid, bin0, bin1, bin2,
        output fout0, fout1, fout2, fvalid_out,
        output bout0, bout1, bout2, bcontrol, bvalid_out
    );

endinterface

`default_nettype wire

// File: rtl/p3_perm.sv
// ============================================================================
//  Module      : p3_perm
//  Description : Combinational 3-position route: pass-through or rotate-left.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module p3_perm
    import p3_to_3_pkg::*;
(
    input  wire logic    control,
    input  wire p3_vec_t din,
    output p3_vec_t      dout
);

    // Rotate: out0 = in1, out1 = in2, out2 = in0.
    always_comb begin
        dout = din;
        if (control == ROTATE) begin
            dout = {din[0], din[2], din[1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/p3_to_3.sv
// ============================================================================
//  Module      : p3_to_3
//  Description : Registered 3-bit router with a backward path that inverts the
//                stored route and reports which route best explains the target.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module p3_to_3
    import p3_to_3_pkg::*;
#(
    parameter logic TIE_SWITCH = 1'b0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    p3_to_3_if.slave   bus
);

    p3_vec_t w_fin;
    p3_vec_t w_bin;
    p3_vec_t w_fwd;
    p3_vec_t w_cur;
    p3_vec_t w_alt;
    p3_vec_t w_bout;
    logic    w_alt_c;
    logic [1:0] w_mc;
    logic [1:0] w_ma;
    logic    w_bcontrol;

    logic    r_ctx_c;
    p3_vec_t r_ctx_fin;
    p3_vec_t r_fout;
    logic    r_fvalid_out;
    p3_vec_t r_bout;
    logic    r_bcontrol;
    logic    r_bvalid_out;

    function automatic logic [1:0] match_count(input p3_vec_t a, input p3_vec_t b);
        p3_vec_t eq;
        eq = ~(a ^ b);
        return {1'b0, eq[0]} + {1'b0, eq[1]} + {1'b0, eq[2]};
    endfunction

    assign w_fin   = {bus.fin2, bus.fin1, bus.fin0};
    assign w_bin   = {bus.bin2, bus.bin1, bus.bin0};
    assign w_alt_c = (r_ctx_c == PASS) ? ROTATE : PASS;

    p3_perm u_perm_fwd (
        .control (bus.fcontrol),
        .din     (w_fin),
        .dout    (w_fwd)
    );

    p3_perm u_perm_cur (
        .control (r_ctx_c),
        .din     (r_ctx_fin),
        .dout    (w_cur)
    );

    p3_perm u_perm_alt (
        .control (w_alt_c),
        .din     (r_ctx_fin),
        .dout    (w_alt)
    );

    // Undo the rotate: bout0 = bin2, bout1 = bin0, bout2 = bin1.
    assign w_bout = (r_ctx_c == ROTATE) ? {w_bin[1], w_bin[0], w_bin[2]} : w_bin;

    assign w_mc = match_count(w_bin, w_cur);
    assign w_ma = match_count(w_bin, w_alt);

    assign w_bcontrol = (w_ma > w_mc) ? 1'b1 :
                        (w_ma < w_mc) ? 1'b0 : TIE_SWITCH;

    // Backward uses the context from before this edge, so a simultaneous
    // forward strobe only affects later backward strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx_c      <= PASS;
            r_ctx_fin    <= '0;
            r_fout       <= '0;
            r_fvalid_out <= 1'b0;
            r_bout       <= '0;
            r_bcontrol   <= 1'b0;
            r_bvalid_out <= 1'b0;
        end else begin
            r_fvalid_out <= bus.fvalid;
            r_bvalid_out <= bus.bvalid;
            if (bus.fvalid) begin
                r_fout    <= w_fwd;
                r_ctx_c   <= bus.fcontrol;
                r_ctx_fin <= w_fin;
            end
            if (bus.bvalid) begin
                r_bout     <= w_bout;
                r_bcontrol <= w_bcontrol;
            end
        end
    end

    assign bus.fout0      = r_fout[0];
    assign bus.fout1      = r_fout[1];
    assign bus.fout2      = r_fout[2];
    assign bus.fvalid_out = r_fvalid_out;
    assign bus.bout0      = r_bout[0];
    assign bus.bout1      = r_bout[1];
    assign bus.bout2      = r_bout[2];
    assign bus.bcontrol   = r_bcontrol;
    assign bus.bvalid_out = r_bvalid_out;

endmodule

`default_nettype wire

// File: tb/tb_p3_to_3.sv
// ============================================================================
//  Module      : tb_p3_to_3
//  Description : Directed and randomised scoreboard bench for p3_to_3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_p3_to_3;

    // Vectors here are written in position order: s = {x0, x1, x2}.
    typedef struct packed {
        logic [2:0] bout;
        logic       bc;
    } bexp_t;

    logic clk;
    logic rst_n;

    p3_to_3_if bus ();

    p3_to_3 #(.TIE_SWITCH(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] fq[$];
    bexp_t      bq[$];
    logic [2:0] last_fout;
    bexp_t      last_b;
    logic       m_c;
    logic [2:0] m_fin;

    function automatic logic [2:0] m_perm(input logic c, input logic [2:0] s);
        return c ? {s[1], s[0], s[2]} : s;
    endfunction

    function automatic logic [2:0] m_inv(input logic c, input logic [2:0] b);
        return c ? {b[0], b[2], b[1]} : b;
    endfunction

    function automatic int m_matches(input logic [2:0] a, input logic [2:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) if (a[i] == b[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [2:0] obs_fout();
        return {bus.fout0, bus.fout1, bus.fout2};
    endfunction

    function automatic logic [2:0] obs_bout();
        return {bus.bout0, bus.bout1, bus.bout2};
    endfunction

    // Drive a forward strobe and push its expected result.
    task automatic fwd(input logic c, input logic [2:0] s);
        bus.fvalid   = 1'b1;
        bus.fcontrol = c;
        {bus.fin0, bus.fin1, bus.fin2} = s;
        fq.push_back(m_perm(c, s));
    endtask

    // Drive a backward strobe; expectation uses the context as it stands now.
    task automatic bwd(input logic [2:0] b);
        bexp_t e;
        int mc, ma;
        bus.bvalid = 1'b1;
        {bus.bin0, bus.bin1, bus.bin2} = b;
        mc = m_matches(b, m_perm(m_c, m_fin));
        ma = m_matches(b, m_perm(~m_c, m_fin));
        e.bout = m_inv(m_c, b);
        e.bc   = (ma > mc) ? 1'b1 : (ma < mc) ? 1'b0 : 1'b0;
        bq.push_back(e);
    endtask

    // Clock one edge, commit model context, check both result channels.
    task automatic step(input string tag);
        bexp_t e;
        logic  fv;
        fv = bus.fvalid;
        @(posedge clk);
        #1;
        if (fv) begin
            m_c   = bus.fcontrol;
            m_fin = {bus.fin0, bus.fin1, bus.fin2};
        end
        bus.fvalid = 1'b0;
        bus.bvalid = 1'b0;
        if (fq.size() > 0) begin
            last_fout = fq.pop_front();
            chk({tag, ".fvalid_out"}, {2'b0, bus.fvalid_out}, 3'b001);
        end else begin
            chk({tag, ".fvalid_out"}, {2'b0, bus.fvalid_out}, 3'b000);
        end
        chk({tag, ".fout"}, obs_fout(), last_fout);
        if (bq.size() > 0) begin
            e = bq.pop_front();
            last_b = e;
            chk({tag, ".bvalid_out"}, {2'b0, bus.bvalid_out}, 3'b001);
        end else begin
            chk({tag, ".bvalid_out"}, {2'b0, bus.bvalid_out}, 3'b000);
        end
        chk({tag, ".bout"}, obs_bout(), last_b.bout);
        chk({tag, ".bcontrol"}, {2'b0, bus.bcontrol}, {2'b0, last_b.bc});
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".fout"}, obs_fout(), 3'b000);
        chk({tag, ".bout"}, obs_bout(), 3'b000);
        chk({tag, ".flags"}, {bus.fvalid_out, bus.bvalid_out, bus.bcontrol}, 3'b000);
    endtask

    task automatic model_reset();
        fq.delete();
        bq.delete();
        last_fout = 3'b000;
        last_b    = '0;
        m_c       = 1'b0;
        m_fin     = 3'b000;
    endtask

    initial begin
        bus.fvalid = 1'b0; bus.fcontrol = 1'b0;
        bus.fin0 = 1'b0; bus.fin1 = 1'b0; bus.fin2 = 1'b0;
        bus.bvalid = 1'b0;
        bus.bin0 = 1'b0; bus.bin1 = 1'b0; bus.bin2 = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset");

        fwd(1'b1, 3'b000); step("rot_000");
        fwd(1'b0, 3'b010); step("pass_010");
        bwd(3'b110);       step("b_tie_110");
        fwd(1'b1, 3'b100); step("rot_100");
        bwd(3'b001);       step("b_cur_001");
        fwd(1'b0, 3'b110); step("pass_110");
        bwd(3'b101);       step("b_alt_101");

        fwd(1'b0, 3'b000); step("ctx_000");
        fwd(1'b1, 3'b111); bwd(3'b000); step("same_cycle");
        bwd(3'b110);       step("b_new_ctx");
        step("hold");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) != 0) fwd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) != 0) bwd(3'($urandom_range(0, 7)));
            step("random");
        end

        fwd(1'b0, 3'b111); bwd(3'b111); step("pre_reset_nonzero");
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_rerst");
        bwd(3'b000); step("b_reset_ctx");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
